div_issue_ctrl: RTL and testbench
=================================

Name: div_issue_ctrl

Overview:
Sequencing controller between the EX stage and the multi-cycle radix-2 divider core (`div_core` sub-module).
- Decodes DIV/DIVU from the ALU control code and latches the operands.
- Drives the core's start/signed/annul controls and stalls the pipeline until the result is ready.
- Buffers the 64-bit result so that a downstream stall never re-issues the division.
- Enforces a watchdog timeout and honours pipeline flush (annul).

Parameters:
- TIMEOUT_CYCLES, 64: maximum BUSY cycles before the core is aborted and err_timeout_o pulses.
- CNT_W, 7: width of the busy-cycle counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- alu_ctrl_i  in  6  EX-stage ALU control code; ALU_DIV / ALU_DIVU start a request
- opdata1_i  in  32  dividend
- opdata2_i  in  32  divisor
- annul_i  in  1  flush of the instruction currently in EX
- pipe_stall_i  in  1  stall from a later stage; EX cannot advance
- result_o  out  64  {remainder[63:32], quotient[31:0]}, valid when result_valid_o=1
- result_valid_o  out  1  result available for the instruction in EX
- stall_div_o  out  1  hold PC/IF/ID/EX
- err_timeout_o  out  1  one-cycle pulse on watchdog abort
- div_start_o  out  1  to core; held high while BUSY
- div_signed_o  out  1  to core; 1 for DIV
- div_op1_o  out  32  to core; latched dividend
- div_op2_o  out  32  to core; latched divisor
- div_annul_o  out  1  to core; one-cycle abort
- div_result_i  in  64  from core
- div_ready_i  in  1  from core; one-cycle completion pulse

Behaviour:
- Reset (rst_n=0, asynchronous) forces:
  - state=IDLE;
  - all registered outputs 0, including result_o, div_op1_o/div_op2_o, div_signed_o and busy_cnt.
  - stall_div_o=0, result_valid_o=0, err_timeout_o=0.
- Reset mid-operation drops the request silently. The core is reset by the same rst_n.
- State IDLE:
  - Request condition: alu_ctrl_i is DIV/DIVU and annul_i=0.
  - On a request: stall_div_o=1 (combinational, same cycle); latch operands and signedness; clear busy_cnt; go to BUSY.
  - A request with annul_i=1 is ignored.
- State BUSY:
  - div_start_o=1 and stall_div_o=1; busy_cnt increments each cycle.
  - div_ready_i=1: capture div_result_i into result_q; go to DONE. stall_div_o stays 1 in this cycle.
  - annul_i=1: div_annul_o=1 for that cycle; go to IDLE; stall_div_o=0 in that cycle. annul_i takes priority over div_ready_i in the same cycle.
  - busy_cnt==TIMEOUT_CYCLES-1 without ready: div_annul_o=1 and err_timeout_o=1 for one cycle; result_q=0; go to DONE, so the pipeline is released with a zero result.
- State DONE:
  - result_valid_o=1, result_o=result_q, stall_div_o=0.
  - pipe_stall_i=1: stay in DONE and hold result_q, with no re-issue.
  - pipe_stall_i=0: go to IDLE. EX advances on the same edge.
  - annul_i=1: go to IDLE; result_valid_o=0 in that cycle.
- IDLE is entered from DONE only when EX has advanced, so a back-to-back division in the next instruction starts cleanly one cycle later.
- Latency: for core latency K (ready pulse K cycles after BUSY entry), stall_div_o is high for K+1 cycles and the result is valid in cycle K+1 after the request.
- Non-division ops: all outputs idle, no state change.
- Operand changes on opdata*_i during BUSY/DONE are ignored; latched copies are used.

Optional Feature:
- DIV_FASTPATH_EN defined:
  - A request whose latched divisor==0 or dividend==0 skips the core: IDLE → DONE directly, div_start_o is never raised, one stall cycle.
  - Dividend==0 gives result 64'h0.
  - Divisor==0 gives {dividend, 32'hFFFF_FFFF}.
  - When both are 0, the divisor rule applies.
- Undefined: every division goes through the core. Divisor-zero results are whatever the core produces.

Decomposition:
- Shared package/header (aludefines): ALU_DIV, ALU_DIVU codes; state encoding IDLE=2'd0, BUSY=2'd1, DONE=2'd2; the result field split constants (REM_MSB=63, QUO_MSB=31).
- One sub-module: div_core, the existing iterative divider. It is instantiated inside div_issue_ctrl, and its port list is mirrored by the div_* signals.

Test Plan:
- DIV 100/7 (signed): stall high K+1 cycles, then result_o=64'h00000002_0000000E with result_valid_o=1 for one cycle.
- DIV -7/2 (0xFFFFFFF9 / 0x2): result_o=64'hFFFFFFFF_FFFFFFFD. DIVU same operands: quotient 0x7FFFFFFC, remainder 0x1.
- Divide 50/5, then pipe_stall_i=1 for 3 cycles in DONE: result held at 64'h0_0000000A for 4 cycles; div_start_o stays 0, with no re-issue.
- annul_i asserted at BUSY cycle 10: div_annul_o pulses once, stall_div_o drops the same cycle, state IDLE, result_valid_o never asserts.
- Core ready forced low, TIMEOUT_CYCLES=64: err_timeout_o pulses at BUSY cycle 64, result_o=0, pipeline released. Separately, rst_n low mid-BUSY: all outputs 0 immediately.
- With DIV_FASTPATH_EN: 0x1234/0 gives 64'h00001234_FFFFFFFF after one stall cycle and div_start_o never high. Without it, the same request goes through the core.

Source files
------------

// File: rtl/div_issue_ctrl_pkg.sv
// Shared ALU codes, controller state encoding and result field split for the divider slice.
package div_issue_ctrl_pkg;

    localparam logic [5:0] ALU_DIV  = 6'b011010;
    localparam logic [5:0] ALU_DIVU = 6'b011011;

    // result = {remainder[REM_MSB:QUO_MSB+1], quotient[QUO_MSB:0]}
    localparam int unsigned REM_MSB = 63;
    localparam int unsigned QUO_MSB = 31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    function automatic logic is_div_op(input logic [5:0] code);
        return (code == ALU_DIV) || (code == ALU_DIVU);
    endfunction

endpackage

// File: rtl/div_core.sv
// Iterative radix-2 restoring divider: one load cycle, 32 iteration cycles, one-cycle ready pulse.
module div_core
    import div_issue_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    logic        busy_q, busy_d;
    logic        ready_q, ready_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvs_q, dvs_d;
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;
    logic [32:0] trial;

    always_comb begin
        busy_d  = busy_q;
        ready_d = 1'b0;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        trial   = {rem_q, quo_q[31]} - {1'b0, dvs_q};

        if (annul_i) begin
            busy_d = 1'b0;
        end else if (busy_q) begin
            rem_d = trial[32] ? {rem_q[30:0], quo_q[31]} : trial[31:0];
            quo_d = {quo_q[30:0], ~trial[32]};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        // Not reloading while ready is up keeps a still-high start from re-running the op.
        end else if (start_i && !ready_q) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            rem_d  = '0;
            quo_d  = (signed_i && op1_i[31]) ? (~op1_i + 32'd1) : op1_i;
            dvs_d  = (signed_i && op2_i[31]) ? (~op2_i + 32'd1) : op2_i;
            negq_d = signed_i && (op1_i[31] ^ op2_i[31]);
            negr_d = signed_i && op1_i[31];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
        end
    end

    assign result_o[REM_MSB:QUO_MSB+1] = negr_q ? (~rem_q + 32'd1) : rem_q;
    assign result_o[QUO_MSB:0]         = negq_q ? (~quo_q + 32'd1) : quo_q;
    assign ready_o                     = ready_q;

endmodule

// File: rtl/div_issue_ctrl.sv
// EX-stage issue controller for div_core (attached on the div_* ports): stall, result buffer, watchdog, annul.
// Optional feature macro: DIV_FASTPATH_EN (zero-operand requests bypass the core).
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  alu_ctrl_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        annul_i,
    input  logic        pipe_stall_i,
    output logic [63:0] result_o,
    output logic        result_valid_o,
    output logic        stall_div_o,
    output logic        err_timeout_o,
    output logic        div_start_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    output logic        div_annul_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
    logic [63:0]      result_q, result_d;
    logic [31:0]      op1_q, op1_d;
    logic [31:0]      op2_q, op2_d;
    logic             signed_q, signed_d;

    always_comb begin
        state_d        = state_q;
        busy_cnt_d     = busy_cnt_q;
        result_d       = result_q;
        op1_d          = op1_q;
        op2_d          = op2_q;
        signed_d       = signed_q;
        stall_div_o    = 1'b0;
        result_valid_o = 1'b0;
        err_timeout_o  = 1'b0;
        div_start_o    = 1'b0;
        div_annul_o    = 1'b0;

        case (state_q)
            IDLE: begin
                // rst_n term keeps the combinational stall low while reset is held.
                if (rst_n && is_div_op(alu_ctrl_i) && !annul_i) begin
                    stall_div_o = 1'b1;
                    op1_d       = opdata1_i;
                    op2_d       = opdata2_i;
                    signed_d    = (alu_ctrl_i == ALU_DIV);
                    busy_cnt_d  = '0;
`ifdef DIV_FASTPATH_EN
                    if (opdata2_i == '0) begin
                        result_d[REM_MSB:QUO_MSB+1] = opdata1_i;
                        result_d[QUO_MSB:0]         = '1;
                        state_d                     = DONE;
                    end else if (opdata1_i == '0) begin
                        result_d = '0;
                        state_d  = DONE;
                    end else begin
                        state_d = BUSY;
                    end
`else
                    state_d = BUSY;
`endif
                end
            end
            BUSY: begin
                div_start_o = 1'b1;
                busy_cnt_d  = busy_cnt_q + CNT_W'(1);
                if (annul_i) begin
                    div_annul_o = 1'b1;
                    state_d     = IDLE;
                end else if (div_ready_i) begin
                    stall_div_o = 1'b1;
                    result_d    = div_result_i;
                    state_d     = DONE;
                end else if (busy_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    stall_div_o   = 1'b1;
                    div_annul_o   = 1'b1;
                    err_timeout_o = 1'b1;
                    result_d      = '0;
                    state_d       = DONE;
                end else begin
                    stall_div_o = 1'b1;
                end
            end
            DONE: begin
                result_valid_o = !annul_i;
                if (annul_i || !pipe_stall_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy_cnt_q <= '0;
            result_q   <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            signed_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_cnt_q <= busy_cnt_d;
            result_q   <= result_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            signed_q   <= signed_d;
        end
    end

    assign result_o     = result_q;
    assign div_signed_o = signed_q;
    assign div_op1_o    = op1_q;
    assign div_op2_o    = op2_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl with div_core attached on the div_* ports; ready can be masked to force a timeout.
module tb_div_issue_ctrl;
    import div_issue_ctrl_pkg::*;

    // div_core: load cycle + 32 iterations, ready lands in the 34th BUSY cycle.
    localparam int K_CORE = 34;
    localparam logic [5:0] ALU_NOP = 6'h00;
    localparam logic [5:0] ALU_ADD = 6'h20;
`ifdef DIV_FASTPATH_EN
    localparam int   ZSTALL = 1;
    localparam logic ZSTART = 1'b0;
`else
    localparam int   ZSTALL = K_CORE + 1;
    localparam logic ZSTART = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  alu_ctrl_i;
    logic [31:0] opdata1_i, opdata2_i;
    logic        annul_i, pipe_stall_i;
    logic [63:0] result_o;
    logic        result_valid_o, stall_div_o, err_timeout_o;
    logic        div_start_o, div_signed_o, div_annul_o;
    logic [31:0] div_op1_o, div_op2_o;
    logic [63:0] core_result;
    logic        core_ready, force_nr;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic [5:0]  alu;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] res;
    } vec_t;
    vec_t vecs[8];

    always #5 clk = ~clk;

    div_issue_ctrl #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .alu_ctrl_i(alu_ctrl_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
        .annul_i(annul_i), .pipe_stall_i(pipe_stall_i),
        .result_o(result_o), .result_valid_o(result_valid_o),
        .stall_div_o(stall_div_o), .err_timeout_o(err_timeout_o),
        .div_start_o(div_start_o), .div_signed_o(div_signed_o),
        .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
        .div_annul_o(div_annul_o),
        .div_result_i(core_result), .div_ready_i(core_ready & ~force_nr)
    );

    div_core u_core (
        .clk(clk), .rst_n(rst_n), .start_i(div_start_o), .signed_i(div_signed_o),
        .op1_i(div_op1_o), .op2_i(div_op2_o), .annul_i(div_annul_o),
        .result_o(core_result), .ready_o(core_ready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        logic [31:0] q, r;
        if (sgn) begin
            sa = a;
            sb = b;
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Result scoreboard: every valid cycle is compared; the entry retires when EX advances.
    always @(negedge clk) begin
        if (rst_n && result_valid_o) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: got %h expected no result", result_o);
            end else begin
                check("sb_result", result_o, exp_q[0]);
                if (!pipe_stall_i) void'(exp_q.pop_front());
            end
        end
    end

    // Call at posedge+#1; returns at the negedge of the first cycle with stall low.
    task automatic run_div(input logic [5:0] alu, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp_res, input int exp_stall, input string tag,
                           output logic saw_start, output int err_cnt, output int err_idx);
        int cnt;
        alu_ctrl_i = alu;
        opdata1_i  = a;
        opdata2_i  = b;
        annul_i    = 1'b0;
        exp_q.push_back(exp_res);
        cnt       = 0;
        saw_start = 1'b0;
        err_cnt   = 0;
        err_idx   = -1;
        @(negedge clk);
        while (stall_div_o && cnt < 200) begin
            if (div_start_o) saw_start = 1'b1;
            if (err_timeout_o) begin
                err_cnt++;
                err_idx = cnt;
            end
            cnt++;
            next_cycle();
            opdata1_i = $urandom;
            opdata2_i = $urandom;
            @(negedge clk);
        end
        check({tag, "_stall_cycles"}, 64'(cnt), 64'(exp_stall));
        check({tag, "_valid"}, 64'(result_valid_o), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no end of test expected completion");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic ss;
        int   ec, ei, annul_cnt, valid_cnt;

        vecs[0] = '{ALU_DIV,  32'd100,        32'd7,          64'h00000002_0000000E};
        vecs[1] = '{ALU_DIV,  32'hFFFF_FFF9,  32'd2,          64'hFFFFFFFF_FFFFFFFD};
        vecs[2] = '{ALU_DIVU, 32'hFFFF_FFF9,  32'd2,          64'h00000001_7FFFFFFC};
        vecs[3] = '{ALU_DIVU, 32'd50,         32'd5,          64'h00000000_0000000A};
        vecs[4] = '{ALU_DIV,  32'd7,          32'hFFFF_FFFE,  64'h00000001_FFFFFFFD};
        vecs[5] = '{ALU_DIV,  32'h8000_0000,  32'd3,          64'hFFFFFFFE_D5555556};
        vecs[6] = '{ALU_DIVU, 32'h8000_0000,  32'd3,          64'h00000002_2AAAAAAA};
        vecs[7] = '{ALU_DIVU, 32'hFFFF_FFFF,  32'd1,          64'h00000000_FFFFFFFF};

        rst_n = 1'b0; alu_ctrl_i = ALU_NOP; opdata1_i = '0; opdata2_i = '0;
        annul_i = 1'b0; pipe_stall_i = 1'b0; force_nr = 1'b0;
        #3;
        check("reset_result", result_o, 64'h0);
        check("reset_ops", {div_op1_o, div_op2_o}, 64'h0);
        check("reset_ctl", 64'({stall_div_o, result_valid_o, err_timeout_o, div_start_o, div_signed_o, div_annul_o}), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Non-division op and an annulled request leave the controller idle.
        next_cycle(); alu_ctrl_i = ALU_ADD; opdata1_i = 32'd5; opdata2_i = 32'd3;
        @(negedge clk);
        check("nondiv_idle", 64'({stall_div_o, div_start_o, result_valid_o, div_annul_o, err_timeout_o}), 64'h0);
        next_cycle(); alu_ctrl_i = ALU_DIV; annul_i = 1'b1;
        @(negedge clk);
        check("annulled_req_stall", 64'(stall_div_o), 64'h0);
        next_cycle(); alu_ctrl_i = ALU_NOP; annul_i = 1'b0;
        @(negedge clk);
        check("annulled_req_idle", 64'({stall_div_o, div_start_o}), 64'h0);

        // Table vectors, issued back-to-back.
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            run_div(vecs[i].alu, vecs[i].a, vecs[i].b, vecs[i].res, K_CORE + 1,
                    $sformatf("vec%0d", i), ss, ec, ei);
            check($sformatf("vec%0d_no_timeout", i), 64'(ec), 64'h0);
        end

        for (int i = 0; i < 4; i++) begin
            logic        s;
            logic [31:0] a, b;
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = 32'($urandom_range(1, 65535));
            next_cycle();
            run_div(s ? ALU_DIV : ALU_DIVU, a, b, ref_div(s, a, b), K_CORE + 1,
                    $sformatf("rnd%0d", i), ss, ec, ei);
        end

        // Downstream stall holds the result in DONE for 4 cycles without re-issue.
        next_cycle(); alu_ctrl_i = ALU_NOP; pipe_stall_i = 1'b1;
        next_cycle();
        run_div(ALU_DIVU, 32'd50, 32'd5, 64'h00000000_0000000A, K_CORE + 1, "hold", ss, ec, ei);
        for (int i = 1; i < 4; i++) begin
            next_cycle();
            if (i == 3) pipe_stall_i = 1'b0;
            @(negedge clk);
            check("hold_no_restart", 64'(div_start_o), 64'h0);
            check("hold_valid", 64'(result_valid_o), 64'h1);
        end
        next_cycle(); alu_ctrl_i = ALU_NOP;
        @(negedge clk);
        check("hold_released", 64'({stall_div_o, result_valid_o, div_start_o}), 64'h0);

        // Asynchronous reset in the middle of BUSY.
        next_cycle(); alu_ctrl_i = ALU_DIV; opdata1_i = 32'd100; opdata2_i = 32'd7;
        repeat (5) next_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_busy_result", result_o, 64'h0);
        check("rst_busy_ops", {div_op1_o, div_op2_o}, 64'h0);
        check("rst_busy_ctl", 64'({stall_div_o, result_valid_o, err_timeout_o, div_start_o, div_signed_o, div_annul_o}), 64'h0);
        @(negedge clk);
        rst_n = 1'b1; alu_ctrl_i = ALU_NOP;
        next_cycle();
        run_div(ALU_DIV, 32'd100, 32'd7, 64'h00000002_0000000E, K_CORE + 1, "post_reset", ss, ec, ei);

        // Flush in the 10th BUSY cycle.
        next_cycle(); alu_ctrl_i = ALU_DIV; opdata1_i = 32'd100; opdata2_i = 32'd7;
        for (int c = 1; c < 10; c++) next_cycle();
        @(negedge clk);
        check("annul_pre_busy", 64'({stall_div_o, div_start_o}), 64'h3);
        next_cycle(); annul_i = 1'b1;
        @(negedge clk);
        check("annul_pulse", 64'(div_annul_o), 64'h1);
        check("annul_stall_drop", 64'(stall_div_o), 64'h0);
        check("annul_no_valid", 64'(result_valid_o), 64'h0);
        next_cycle(); annul_i = 1'b0; alu_ctrl_i = ALU_NOP;
        annul_cnt = 0; valid_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (div_annul_o) annul_cnt++;
            if (result_valid_o || stall_div_o) valid_cnt++;
            next_cycle();
        end
        check("annul_single_pulse", 64'(annul_cnt), 64'h0);
        check("annul_quiet_after", 64'(valid_cnt), 64'h0);

        // Watchdog: ready masked, abort in BUSY cycle 64 with a zero result.
        force_nr = 1'b1;
        run_div(ALU_DIV, 32'd100, 32'd7, 64'h0, 65, "timeout", ss, ec, ei);
        check("timeout_pulses", 64'(ec), 64'h1);
        check("timeout_cycle", 64'(ei), 64'd64);
        force_nr = 1'b0;

        // Zero-operand requests.
        next_cycle();
        run_div(ALU_DIVU, 32'h1234, 32'h0, 64'h00001234_FFFFFFFF, ZSTALL, "div_by_zero", ss, ec, ei);
        check("div_by_zero_start", 64'(ss), 64'(ZSTART));
        next_cycle();
        run_div(ALU_DIV, 32'h0, 32'd5, 64'h0, ZSTALL, "zero_dividend", ss, ec, ei);
        check("zero_dividend_start", 64'(ss), 64'(ZSTART));
        next_cycle();
        run_div(ALU_DIVU, 32'h0, 32'h0, 64'h00000000_FFFFFFFF, ZSTALL, "both_zero", ss, ec, ei);

        next_cycle(); alu_ctrl_i = ALU_NOP;
        repeat (3) next_cycle();
        check("sb_drained", 64'(exp_q.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
